// File: rtl/ocd_io_out_seq.sv
// Output-direction sequencer for a bidirectional pad: setup window before OE rises,
// tri-state dead time after OE falls, per-burst drive latching and a synchronised bus keeper.
module ocd_io_out_seq #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned TURN_CYC  = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       A,
  input  logic       OE_REQ,
  input  logic [1:0] DRV_SEL,
  input  logic       SLEW,
  input  logic       KEEP_EN,
  input  logic       Y,
  output logic       PAD_A,
  output logic       PAD_OE,
  output logic       PAD_PDRV0,
  output logic       PAD_PDRV1,
  output logic       PAD_SL,
  output logic       PAD_PU,
  output logic       PAD_PD,
  output logic       DRIVING,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    ST_HIZ,
    ST_PRE_DRV,
    ST_DRIVE,
    ST_POST_DRV
  } state_e;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'(TURN_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       drv_q, drv_d;
  logic             sl_q, sl_d;
  logic             pad_a_q, pad_a_d;
  logic             pad_oe_q, pad_oe_d;
  logic             busy_q, busy_d;
  logic             pu_q, pu_d;
  logic             pd_q, pd_d;
  logic             y_meta_q, y_meta_d;
  logic             keep_on;

  // Next-state logic for the direction sequencer.
  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drv_d   = drv_q;
    sl_d    = sl_q;

    unique case (state_q)
      ST_HIZ: begin
        if (OE_REQ) begin
          drv_d = DRV_SEL;
          sl_d  = SLEW;
          if (SETUP_CYC == 0) begin
            state_d = ST_DRIVE;
          end else begin
            state_d = ST_PRE_DRV;
            cnt_d   = SETUP_LD;
          end
        end
      end

      ST_PRE_DRV: begin
        // A dropped request aborts before OE ever rises, so no dead time is owed.
        if (!OE_REQ) begin
          state_d = ST_HIZ;
          cnt_d   = '0;
        end else if (cnt_q == CNT_ONE) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_DRIVE: begin
        if (!OE_REQ) begin
          if (TURN_CYC == 0) begin
            state_d = ST_HIZ;
          end else begin
            state_d = ST_POST_DRV;
            cnt_d   = TURN_LD;
          end
        end
      end

      ST_POST_DRV: begin
        // Dead time always runs to completion; a new request is seen from HIZ.
        if (cnt_q == CNT_ONE) begin
          state_d = ST_HIZ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = ST_HIZ;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so each one lands in a flop with the state change.
  always_comb begin
    y_meta_d = Y;
    pad_oe_d = (state_d == ST_DRIVE);
    busy_d   = (state_d == ST_PRE_DRV) || (state_d == ST_POST_DRV);
    pad_a_d  = ((state_d == ST_PRE_DRV) || (state_d == ST_DRIVE)) ? A : pad_a_q;

    // The pu/pd registers form the second synchroniser stage behind y_meta_q.
    keep_on  = (state_d == ST_HIZ) && KEEP_EN;
    pu_d     = keep_on && y_meta_q;
    pd_d     = keep_on && !y_meta_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_HIZ;
      cnt_q    <= '0;
      drv_q    <= '0;
      sl_q     <= 1'b0;
      pad_a_q  <= 1'b0;
      pad_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      pu_q     <= 1'b0;
      pd_q     <= 1'b0;
      y_meta_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drv_q    <= drv_d;
      sl_q     <= sl_d;
      pad_a_q  <= pad_a_d;
      pad_oe_q <= pad_oe_d;
      busy_q   <= busy_d;
      pu_q     <= pu_d;
      pd_q     <= pd_d;
      y_meta_q <= y_meta_d;
    end
  end

  assign PAD_A     = pad_a_q;
  assign PAD_OE    = pad_oe_q;
  assign PAD_PDRV0 = drv_q[0];
  assign PAD_PDRV1 = drv_q[1];
  assign PAD_SL    = sl_q;
  assign PAD_PU    = pu_q;
  assign PAD_PD    = pd_q;
  assign DRIVING   = pad_oe_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_ocd_io_out_seq.sv
// Directed bench for ocd_io_out_seq: three instances (2/4, 3/4 and 0/0 setup/turn cycles)
// share the inputs; each scenario checks the instance it targets.
module tb_ocd_io_out_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       A = 1'b0;
  logic       OE_REQ = 1'b0;
  logic [1:0] DRV_SEL = 2'b00;
  logic       SLEW = 1'b0;
  logic       KEEP_EN = 1'b0;
  logic       Y = 1'b0;

  // Packed view: {OE, DRIVING, BUSY, PDRV1, PDRV0, SL, PU, PD, PAD_A}
  wire [8:0] m_out;
  wire [8:0] a_out;
  wire [8:0] z_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  ocd_io_out_seq #(.SETUP_CYC(2), .TURN_CYC(4), .CNT_W(8)) u_main (
    .CLK(CLK), .RST(RST), .A(A), .OE_REQ(OE_REQ), .DRV_SEL(DRV_SEL), .SLEW(SLEW),
    .KEEP_EN(KEEP_EN), .Y(Y),
    .PAD_A(m_out[0]), .PAD_OE(m_out[8]), .PAD_PDRV0(m_out[4]), .PAD_PDRV1(m_out[5]),
    .PAD_SL(m_out[3]), .PAD_PU(m_out[2]), .PAD_PD(m_out[1]), .DRIVING(m_out[7]), .BUSY(m_out[6])
  );

  ocd_io_out_seq #(.SETUP_CYC(3), .TURN_CYC(4), .CNT_W(8)) u_abort (
    .CLK(CLK), .RST(RST), .A(A), .OE_REQ(OE_REQ), .DRV_SEL(DRV_SEL), .SLEW(SLEW),
    .KEEP_EN(KEEP_EN), .Y(Y),
    .PAD_A(a_out[0]), .PAD_OE(a_out[8]), .PAD_PDRV0(a_out[4]), .PAD_PDRV1(a_out[5]),
    .PAD_SL(a_out[3]), .PAD_PU(a_out[2]), .PAD_PD(a_out[1]), .DRIVING(a_out[7]), .BUSY(a_out[6])
  );

  ocd_io_out_seq #(.SETUP_CYC(0), .TURN_CYC(0), .CNT_W(8)) u_zero (
    .CLK(CLK), .RST(RST), .A(A), .OE_REQ(OE_REQ), .DRV_SEL(DRV_SEL), .SLEW(SLEW),
    .KEEP_EN(KEEP_EN), .Y(Y),
    .PAD_A(z_out[0]), .PAD_OE(z_out[8]), .PAD_PDRV0(z_out[4]), .PAD_PDRV1(z_out[5]),
    .PAD_SL(z_out[3]), .PAD_PU(z_out[2]), .PAD_PD(z_out[1]), .DRIVING(z_out[7]), .BUSY(z_out[6])
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic go_idle();
    OE_REQ  = 1'b0;
    KEEP_EN = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    #1 RST = 1'b1;
    #1;
    n_checks++;
    if ({m_out, a_out, z_out} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_assert: got %b expected all zero", {m_out, a_out, z_out});
    end
    #5 RST = 1'b0;
    tick();
    n_checks++;
    if ({m_out, a_out, z_out} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected all zero", {m_out, a_out, z_out});
    end
  endtask

  task automatic test_turn_on();
    A = 1'b1; DRV_SEL = 2'b10; SLEW = 1'b1; OE_REQ = 1'b1;
    tick();
    n_checks++;
    if (m_out !== 9'b001101001) begin
      n_fail++;
      $display("FAIL turn_on_c1: got %b expected %b", m_out, 9'b001101001);
    end
    A = 1'b0;
    tick();
    n_checks++;
    if (m_out !== 9'b001101000) begin
      n_fail++;
      $display("FAIL turn_on_c2: got %b expected %b", m_out, 9'b001101000);
    end
    A = 1'b1;
    tick();
    n_checks++;
    if (m_out !== 9'b110101001) begin
      n_fail++;
      $display("FAIL turn_on_c3: got %b expected %b", m_out, 9'b110101001);
    end
  endtask

  task automatic test_drv_hold();
    DRV_SEL = 2'b01; SLEW = 1'b0; A = 1'b0;
    tick();
    n_checks++;
    if (m_out !== 9'b110101000) begin
      n_fail++;
      $display("FAIL drv_hold: got %b expected %b", m_out, 9'b110101000);
    end
  endtask

  task automatic test_turn_off();
    OE_REQ = 1'b0; A = 1'b1;
    tick();
    n_checks++;
    if (m_out !== 9'b001101000) begin
      n_fail++;
      $display("FAIL turn_off_c1: got %b expected %b", m_out, 9'b001101000);
    end
    OE_REQ = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (m_out !== 9'b001101000) begin
        n_fail++;
        $display("FAIL turn_off_dead_%0d: got %b expected %b", k, m_out, 9'b001101000);
      end
    end
    tick();
    n_checks++;
    if (m_out !== 9'b000101000) begin
      n_fail++;
      $display("FAIL turn_off_hiz: got %b expected %b", m_out, 9'b000101000);
    end
    tick();
    n_checks++;
    if (m_out !== 9'b001010001) begin
      n_fail++;
      $display("FAIL turn_off_rearm: got %b expected %b", m_out, 9'b001010001);
    end
    go_idle();
  endtask

  task automatic test_abort();
    logic oe_seen;
    int   busy_cnt;
    oe_seen  = 1'b0;
    busy_cnt = 0;
    A = 1'b0; OE_REQ = 1'b1;
    tick();
    n_checks++;
    if (a_out[8:6] !== 3'b001) begin
      n_fail++;
      $display("FAIL abort_pre: got %b expected %b", a_out[8:6], 3'b001);
    end
    OE_REQ = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      oe_seen  = oe_seen | a_out[8];
      busy_cnt = busy_cnt + int'(a_out[6]);
    end
    n_checks++;
    if (oe_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_oe: got %b expected 0", oe_seen);
    end
    n_checks++;
    if (busy_cnt != 0) begin
      n_fail++;
      $display("FAIL abort_no_dead_time: got %0d busy cycles expected 0", busy_cnt);
    end
    go_idle();
  endtask

  task automatic test_keeper();
    Y = 1'b0; KEEP_EN = 1'b1;
    tick(); tick();
    n_checks++;
    if (m_out[2:1] !== 2'b01) begin
      n_fail++;
      $display("FAIL keeper_low: got %b expected %b", m_out[2:1], 2'b01);
    end
    Y = 1'b1;
    tick();
    n_checks++;
    if (m_out[2:1] !== 2'b01) begin
      n_fail++;
      $display("FAIL keeper_sync_c1: got %b expected %b", m_out[2:1], 2'b01);
    end
    tick();
    n_checks++;
    if (m_out[2:1] !== 2'b10) begin
      n_fail++;
      $display("FAIL keeper_sync_c2: got %b expected %b", m_out[2:1], 2'b10);
    end
    KEEP_EN = 1'b0;
    tick();
    n_checks++;
    if (m_out[2:1] !== 2'b00) begin
      n_fail++;
      $display("FAIL keeper_disable: got %b expected %b", m_out[2:1], 2'b00);
    end
    KEEP_EN = 1'b1;
    tick();
    n_checks++;
    if (m_out[2:1] !== 2'b10) begin
      n_fail++;
      $display("FAIL keeper_reenable: got %b expected %b", m_out[2:1], 2'b10);
    end
    OE_REQ = 1'b1;
    tick();
    n_checks++;
    if ({m_out[6], m_out[2:1]} !== 3'b100) begin
      n_fail++;
      $display("FAIL keeper_off_pre: got %b expected %b", {m_out[6], m_out[2:1]}, 3'b100);
    end
    tick(); tick();
    n_checks++;
    if ({m_out[8], m_out[2:1]} !== 3'b100) begin
      n_fail++;
      $display("FAIL keeper_off_drive: got %b expected %b", {m_out[8], m_out[2:1]}, 3'b100);
    end
    Y = 1'b0;
    go_idle();
  endtask

  task automatic test_zero_delay();
    DRV_SEL = 2'b11; SLEW = 1'b1; A = 1'b1; OE_REQ = 1'b1;
    tick();
    n_checks++;
    if (z_out !== 9'b110111001) begin
      n_fail++;
      $display("FAIL zero_on: got %b expected %b", z_out, 9'b110111001);
    end
    OE_REQ = 1'b0;
    tick();
    n_checks++;
    if (z_out !== 9'b000111001) begin
      n_fail++;
      $display("FAIL zero_off: got %b expected %b", z_out, 9'b000111001);
    end
    DRV_SEL = 2'b00; SLEW = 1'b0; OE_REQ = 1'b1;
    tick();
    n_checks++;
    if (z_out !== 9'b110000001) begin
      n_fail++;
      $display("FAIL zero_back_to_back: got %b expected %b", z_out, 9'b110000001);
    end
    go_idle();
  endtask

  task automatic test_async_reset();
    A = 1'b1; OE_REQ = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (m_out[8] !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre_drive: got %b expected 1", m_out[8]);
    end
    #2 RST = 1'b1;
    #1;
    n_checks++;
    if ({m_out, a_out, z_out} !== 27'd0) begin
      n_fail++;
      $display("FAIL areset_mid_drive: got %b expected all zero", {m_out, a_out, z_out});
    end
    OE_REQ = 1'b0;
    #2 RST = 1'b0;
    tick();
    n_checks++;
    if ({m_out, a_out, z_out} !== 27'd0) begin
      n_fail++;
      $display("FAIL areset_release: got %b expected all zero", {m_out, a_out, z_out});
    end
  endtask

  initial begin
    test_reset();
    test_turn_on();
    test_drv_hold();
    test_turn_off();
    test_abort();
    test_keeper();
    test_zero_delay();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
